pga_spi_writer: RTL and testbench

PGA_SPI_WRITER -- requirements
Module: pga_spi_writer

---
 rtl/pga_spi_writer.sv | 194 +++++++++++++++++++
 tb/tb_pga_spi_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pga_spi_writer.sv
// SPI mode-0 writer that loads an 8-bit gain code into a PGA register, one 16-bit frame per request.
// Optional macro PGA_READBACK_EN appends a read frame and flags a mismatch on readback_err_o.
module pga_spi_writer #(
    parameter int         CLK_DIV  = 4,
    parameter logic [6:0] REG_ADDR = 7'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pga_code_i,
    input  logic       set_pga_i,
    output logic       pga_ready_o,
    output logic       spi_cs_n_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       readback_err_o
);

`ifdef PGA_READBACK_EN
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP, RB_SETUP, RB_SHIFT, RB_HOLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_r;
    logic [7:0]  div_r;
    logic [4:0]  bit_r;
    logic [14:0] shreg_r;
    logic [7:0]  code_r;
    logic        ready_r;
    logic        cs_n_r;
    logic        sclk_r;
    logic        mosi_r;
    logic        div_done_s;
`ifdef PGA_READBACK_EN
    logic [7:0]  rb_r;
    logic        err_r;
    logic        rb_phase_r;
`endif

    assign div_done_s = (div_r == DIV_LAST);

    // Frame sequencer: every phase is a whole number of CLK_DIV periods; bit 15 is driven straight onto MOSI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            div_r   <= 8'd0;
            bit_r   <= 5'd0;
            shreg_r <= 15'h0000;
            code_r  <= 8'h00;
            ready_r <= 1'b1;
            cs_n_r  <= 1'b1;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
`ifdef PGA_READBACK_EN
            rb_r       <= 8'h00;
            err_r      <= 1'b0;
            rb_phase_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (set_pga_i) begin
                        code_r  <= pga_code_i;
                        shreg_r <= {REG_ADDR, pga_code_i};
                        mosi_r  <= 1'b0;
                        cs_n_r  <= 1'b0;
                        ready_r <= 1'b0;
                        div_r   <= 8'd0;
                        state_r <= CS_SETUP;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
`ifdef PGA_READBACK_EN
                CS_SETUP, RB_SETUP: begin
`else
                CS_SETUP: begin
`endif
                    if (div_done_s) begin
                        div_r <= 8'd0;
                        bit_r <= 5'd0;
`ifdef PGA_READBACK_EN
                        state_r <= (state_r == RB_SETUP) ? RB_SHIFT : SHIFT;
`else
                        state_r <= SHIFT;
`endif
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
`ifdef PGA_READBACK_EN
                SHIFT, RB_SHIFT: begin
`else
                SHIFT: begin
`endif
                    if (!div_done_s) begin
                        div_r <= div_r + 8'd1;
                    end else if (!sclk_r) begin
                        div_r  <= 8'd0;
                        sclk_r <= 1'b1;
`ifdef PGA_READBACK_EN
                        // Data byte occupies bit slots 8..15 of the read frame.
                        if (state_r == RB_SHIFT && bit_r[3]) begin
                            rb_r <= {rb_r[6:0], spi_miso_i};
                        end
`endif
                    end else if (bit_r == 5'd15) begin
                        div_r  <= 8'd0;
                        sclk_r <= 1'b0;
                        mosi_r <= 1'b0;
`ifdef PGA_READBACK_EN
                        state_r <= (state_r == RB_SHIFT) ? RB_HOLD : CS_HOLD;
`else
                        state_r <= CS_HOLD;
`endif
                    end else begin
                        div_r   <= 8'd0;
                        sclk_r  <= 1'b0;
                        bit_r   <= bit_r + 5'd1;
                        mosi_r  <= shreg_r[14];
                        shreg_r <= {shreg_r[13:0], 1'b0};
                    end
                end
`ifdef PGA_READBACK_EN
                CS_HOLD, RB_HOLD: begin
`else
                CS_HOLD: begin
`endif
                    if (div_done_s) begin
                        div_r   <= 8'd0;
                        cs_n_r  <= 1'b1;
                        mosi_r  <= 1'b0;
                        state_r <= CS_GAP;
`ifdef PGA_READBACK_EN
                        if (state_r == RB_HOLD) begin
                            err_r <= err_r | (rb_r != code_r);
                        end
`endif
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                CS_GAP: begin
                    if (div_done_s) begin
                        div_r <= 8'd0;
`ifdef PGA_READBACK_EN
                        if (!rb_phase_r) begin
                            rb_phase_r <= 1'b1;
                            shreg_r    <= {REG_ADDR, 8'h00};
                            mosi_r     <= 1'b1;
                            cs_n_r     <= 1'b0;
                            rb_r       <= 8'h00;
                            state_r    <= RB_SETUP;
                        end else begin
                            rb_phase_r <= 1'b0;
                            ready_r    <= 1'b1;
                            state_r    <= IDLE;
                        end
`else
                        ready_r <= 1'b1;
                        state_r <= IDLE;
`endif
                    end else begin
                        div_r <= div_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    cs_n_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pga_ready_o = ready_r;
    assign spi_cs_n_o  = cs_n_r;
    assign spi_sclk_o  = sclk_r;
    assign spi_mosi_o  = mosi_r;

`ifdef PGA_READBACK_EN
    assign readback_err_o = err_r;
`else
    logic unused_s;
    assign unused_s       = spi_miso_i ^ (^code_r);
    assign readback_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pga_spi_writer.sv
// Self-checking bench for pga_spi_writer: table vectors, random codes against a frame-level model,
// plus sequences for held requests, mid-frame reset and (with PGA_READBACK_EN) readback mismatch.
module tb_pga_spi_writer;

    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] REG_ADDR = 7'h02;
`ifdef PGA_READBACK_EN
    localparam int FRAMES_PER_REQ = 2;
    localparam int BUSY_CYCLES    = 70 * CLK_DIV;
`else
    localparam int FRAMES_PER_REQ = 1;
    localparam int BUSY_CYCLES    = 35 * CLK_DIV;
`endif
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pga_code_i = 8'h00;
    logic       set_pga_i = 1'b0;
    logic       pga_ready_o;
    logic       spi_cs_n_o;
    logic       spi_sclk_o;
    logic       spi_mosi_o;
    logic       spi_miso_i = 1'b0;
    logic       readback_err_o;

    pga_spi_writer #(.CLK_DIV(CLK_DIV), .REG_ADDR(REG_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .pga_code_i(pga_code_i), .set_pga_i(set_pga_i),
        .pga_ready_o(pga_ready_o), .spi_cs_n_o(spi_cs_n_o), .spi_sclk_o(spi_sclk_o),
        .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i), .readback_err_o(readback_err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI slave model: captures MOSI on SCLK rise, serves miso_byte in bit slots 8..15.
    typedef struct {int rises; logic [15:0] word;} frame_t;
    frame_t      frames[$];
    int          nrise = 0;
    logic [15:0] cap = 16'h0000;
    logic [7:0]  miso_byte = 8'h00;
    logic        mon_cs = 1'b1;
    logic        mon_sclk = 1'b0;

    always @(spi_sclk_o or spi_cs_n_o) begin
        if (spi_cs_n_o !== mon_cs) begin
            if (spi_cs_n_o === 1'b0) begin
                nrise = 0;
                cap   = 16'h0000;
            end else if (mon_cs === 1'b0) begin
                frames.push_back('{nrise, cap});
            end
            mon_cs = spi_cs_n_o;
        end
        if (spi_sclk_o === 1'b1 && mon_sclk !== 1'b1) begin
            cap = {cap[14:0], spi_mosi_o};
            nrise++;
            spi_miso_i = (nrise >= 8 && nrise < 16) ? miso_byte[15 - nrise] : 1'b0;
        end
        mon_sclk = spi_sclk_o;
    end

    // Bus invariants: SCLK/MOSI quiet with CS high, MOSI stable while SCLK high.
    int   viol = 0;
    logic inv_sclk = 1'b0;
    logic inv_mosi = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (spi_sclk_o && spi_cs_n_o) begin viol++; $display("protocol violation: sclk high with cs_n high at %0t", $time); end
            if (spi_mosi_o && spi_cs_n_o) begin viol++; $display("protocol violation: mosi high with cs_n high at %0t", $time); end
            if (inv_sclk && spi_sclk_o && (spi_mosi_o != inv_mosi)) begin viol++; $display("protocol violation: mosi moved with sclk high at %0t", $time); end
        end
        inv_sclk = spi_sclk_o;
        inv_mosi = spi_mosi_o;
    end

    task automatic wait_ready(input string tag);
        int g = 0;
        @(negedge clk);
        while (!pga_ready_o && g < LIMIT) begin g++; @(negedge clk); end
        if (g >= LIMIT) check({tag, " ready timeout"}, 32'd0, 32'd1);
    endtask

    // One request: returns busy length, first cycle (1 = cycle after acceptance) where the error flag rose, and ready just after acceptance.
    task automatic run_frame(input logic [7:0] code, input logic [7:0] mb,
                             output int busy, output int err_cyc, output logic rdy_after);
        logic err_before;
        miso_byte = mb;
        frames.delete();
        wait_ready("run");
        err_before = readback_err_o;
        pga_code_i = code;
        set_pga_i  = 1'b1;
        @(posedge clk); #1;
        set_pga_i  = 1'b0;
        pga_code_i = ~code;
        rdy_after  = pga_ready_o;
        busy = 0;
        err_cyc = 0;
        while (!pga_ready_o && busy < LIMIT) begin
            busy++;
            @(posedge clk); #1;
            if (readback_err_o && !err_before && err_cyc == 0) err_cyc = busy + 1;
        end
    endtask

    task automatic check_frames(input string tag, input logic [7:0] code);
        logic [15:0] exp_w = {1'b0, REG_ADDR, code};
        check({tag, " frames"}, frames.size(), FRAMES_PER_REQ);
        if (frames.size() >= 1) begin
            check({tag, " word"}, frames[0].word, exp_w);
            check({tag, " pulses"}, frames[0].rises, 16);
        end
`ifdef PGA_READBACK_EN
        if (frames.size() >= 2) begin
            check({tag, " rd word"}, frames[1].word, {1'b1, REG_ADDR, 8'h00});
            check({tag, " rd pulses"}, frames[1].rises, 16);
        end
`endif
    endtask

    typedef struct {logic [7:0] code; logic [15:0] exp_word;} vec_t;
    vec_t tbl[5];

    initial begin
        int busy, errc, g, r9;
        logic rdy;
        logic [7:0] code;

        tbl[0] = '{8'hA5, 16'h02A5};
        tbl[1] = '{8'h00, 16'h0200};
        tbl[2] = '{8'hFF, 16'h02FF};
        tbl[3] = '{8'h5A, 16'h025A};
        tbl[4] = '{8'h81, 16'h0281};

        repeat (3) @(negedge clk);
        check("rst ready", pga_ready_o, 1);
        check("rst cs_n", spi_cs_n_o, 1);
        check("rst sclk", spi_sclk_o, 0);
        check("rst err", readback_err_o, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle ready", pga_ready_o, 1);
        check("idle cs_n", spi_cs_n_o, 1);
        check("idle sclk", spi_sclk_o, 0);
        check("idle mosi", spi_mosi_o, 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].code, tbl[i].code, busy, errc, rdy);
            check("tbl ready after accept", rdy, 0);
            check("tbl busy", busy, BUSY_CYCLES);
            check("tbl err", errc, 0);
            check("tbl word", (frames.size() >= 1) ? frames[0].word : 16'hxxxx, tbl[i].exp_word);
            check_frames("tbl", tbl[i].code);
        end

        for (int i = 0; i < 6; i++) begin
            code = 8'($urandom);
            run_frame(code, code, busy, errc, rdy);
            check("rnd ready after accept", rdy, 0);
            check("rnd busy", busy, BUSY_CYCLES);
            check_frames("rnd", code);
        end

        // Request held high across the transfer while the code changes underneath.
        frames.delete();
        miso_byte = 8'h10;
        wait_ready("hold");
        pga_code_i = 8'h10;
        set_pga_i  = 1'b1;
        @(posedge clk); #1;
        pga_code_i = 8'h20;
        check("hold ready low", pga_ready_o, 0);
        busy = 0;
        while (!pga_ready_o && busy < LIMIT) begin busy++; @(posedge clk); #1; end
        check("hold busy", busy, BUSY_CYCLES);
        check("hold cs idle", spi_cs_n_o, 1);
        check_frames("hold first", 8'h10);
        miso_byte = 8'h20;
        @(posedge clk); #1;
        set_pga_i = 1'b0;
        check("hold second accept", pga_ready_o, 0);
        check("hold second cs", spi_cs_n_o, 0);
        wait_ready("hold2");
        check("hold total frames", frames.size(), 2 * FRAMES_PER_REQ);
        if (frames.size() > FRAMES_PER_REQ)
            check("hold second word", frames[FRAMES_PER_REQ].word, {1'b0, REG_ADDR, 8'h20});

        // Reset in the middle of bit 9.
        frames.delete();
        wait_ready("rst");
        pga_code_i = 8'h3C;
        set_pga_i  = 1'b1;
        @(posedge clk); #1;
        set_pga_i = 1'b0;
        g = 0;
        while (nrise < 9 && g < LIMIT) begin g++; @(negedge clk); end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort cs_n", spi_cs_n_o, 1);
        check("abort sclk", spi_sclk_o, 0);
        check("abort ready", pga_ready_o, 1);
        r9 = nrise;
        check("abort at bit9", r9, 9);
        repeat (4) @(negedge clk);
        check("abort no edges", nrise, r9);
        rst_n = 1'b1;
        run_frame(8'hC3, 8'hC3, busy, errc, rdy);
        check("post-rst busy", busy, BUSY_CYCLES);
        check_frames("post-rst", 8'hC3);

`ifdef PGA_READBACK_EN
        run_frame(8'hA5, 8'hA4, busy, errc, rdy);
        check("rb mismatch err cycle", errc, 69 * CLK_DIV + 1);
        check("rb mismatch busy", busy, 280);
        run_frame(8'h5A, 8'h5A, busy, errc, rdy);
        check("rb sticky", readback_err_o, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rb cleared by reset", readback_err_o, 0);
        rst_n = 1'b1;
`else
        run_frame(8'hA5, 8'hA4, busy, errc, rdy);
        check("no-rb err", readback_err_o, 0);
        check("no-rb busy", busy, BUSY_CYCLES);
`endif

        check("bus invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
